// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debounce front end: per-key FSM encoding,
// time-base constant and an elaboration-time helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int MS_PER_S = 1000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce/hold FSM and its ms counters.
// The auto-repeat counter exists only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
`ifdef KEY_AUTOREPEAT_EN
    parameter int REPEAT_MS      = 100,
`endif
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tick_i,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CNT_W = $clog2(max_int(LONG_MS, DEBOUNCE_MS) + 1);
    localparam logic             RAW_IDLE  = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_MS);

    logic             sync1_q, sync2_q;
    logic             pressed_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
`ifdef KEY_AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_MS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Flops reset to the released level so reset release never looks like a press.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = sync2_q ^ RAW_IDLE;

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pressed_s) begin
                    state_d   = ST_PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = ST_IDLE;
                end else if (tick_i) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d    = ST_PRESSED;
                        press_d    = 1'b1;
                        level_d    = 1'b1;
                        deb_cnt_d  = '0;
                        hold_cnt_d = '0;
`ifdef KEY_AUTOREPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) begin
                    state_d   = ST_RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else if (tick_i) begin
                    // Hold counter saturates at LONG_MS, so key_long fires once per hold.
                    if (hold_cnt_q != LONG_SAT) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                        long_d     = (hold_cnt_q == LONG_LAST);
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rep_cnt_q == REP_LAST) begin
                        press_d   = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back to pressed keeps the hold time already accumulated.
                if (pressed_s) begin
                    state_d   = ST_PRESSED;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else if (tick_i) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
`endif
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: shared 1 ms tick prescaler plus one debounce channel per key.
// Define KEY_AUTOREPEAT_EN to make held keys re-emit key_press every REPEAT_MS after key_long.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS         = 7,
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 100,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              any_press
);

    localparam int TICK_DIV = CLK_HZ / MS_PER_S;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    if (TICK_DIV < 1 || DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_params
        $error("key_debounce: CLK_HZ must be >= 1000 and all ms periods >= 1");
    end

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;

    assign tick    = (presc_q == PRE_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_MS       (LONG_MS),
`ifdef KEY_AUTOREPEAT_EN
            .REPEAT_MS     (REPEAT_MS),
`endif
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_ch (
            .clk_i    (CLOCK_50),
            .rst_n_i  (rst_n),
            .tick_i   (tick),
            .key_raw_i(keys[gi]),
            .level_o  (key_level[gi]),
            .press_o  (key_press[gi]),
            .release_o(key_release[gi]),
            .long_o   (key_long[gi])
        );
    end

    // Channel pulses are already registered, so the OR stays in the same cycle.
    assign any_press = |key_press;

endmodule
